// File: rtl/frog_pkg.sv
// Shared types and grid constants for the frog tracker.
package frog_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    WIN  = 2'd2,
    OVER = 2'd3
  } state_e;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  localparam logic [3:0] START_X = 4'd7;
  localparam logic [3:0] START_Y = 4'd0;
  localparam logic [3:0] GOAL_Y  = 4'd15;

endpackage

// File: rtl/frog_step.sv
// Combinational move resolver: single-move priority up > down > left > right.
// Column wraps at the grid edges when FROG_WRAP_EN is defined, otherwise saturates.
module frog_step
  import frog_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [3:0] nx,
  output logic [3:0] ny
);

  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

  always_comb begin
    nx = x;
    ny = y;
    if (up) begin
      if (y != Y_MAX) ny = y + 4'd1;
    end else if (down) begin
      if (y != 4'd0) ny = y - 4'd1;
    end else if (left) begin
`ifdef FROG_WRAP_EN
      nx = (x == 4'd0) ? X_MAX : x - 4'd1;
`else
      if (x != 4'd0) nx = x - 4'd1;
`endif
    end else if (right) begin
`ifdef FROG_WRAP_EN
      nx = (x == X_MAX) ? 4'd0 : x + 4'd1;
`else
      if (x != X_MAX) nx = x + 4'd1;
`endif
    end
  end

endmodule

// File: rtl/frog_tracker.sv
// Frog crossing game tracker: position, collision, lives and score.
// Column wrap-around is enabled by defining FROG_WRAP_EN.
//   state | meaning
//   PLAY  | accepting moves, checking collisions and goal
//   HIT   | collision hold, position parked at start
//   WIN   | crossing hold, position parked at start
//   OVER  | no lives left, frozen until hardReset
module frog_tracker
  import frog_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              hardReset,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic [15:0][15:0] lanes,
  output logic [3:0]        frog_x,
  output logic [3:0]        frog_y,
  output logic              hit,
  output logic              win,
  output logic [1:0]        lives,
  output logic [3:0]        score,
  output logic              game_over
);

  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYCLES);
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);

  state_e      state_q, state_d;
  logic [3:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  score_q, score_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  nx, ny;
  logic        collide;

  frog_step u_step (
    .x     (x_q),
    .y     (y_q),
    .up    (up),
    .down  (down),
    .left  (left),
    .right (right),
    .nx    (nx),
    .ny    (ny)
  );

  // Lookup at the candidate cell also catches a car arriving on a still frog.
  assign collide = lanes[ny][nx];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    case (state_q)
      PLAY: begin
        if (collide) begin
          state_d = HIT;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          x_d     = START_X;
          y_d     = START_Y;
          cnt_d   = HOLD_INIT;
        end else if (ny == GOAL_Y) begin
          state_d = WIN;
          if (score_q != 4'hF) score_d = score_q + 4'd1;
          x_d     = START_X;
          y_d     = START_Y;
          cnt_d   = HOLD_INIT;
        end else begin
          x_d = nx;
          y_d = ny;
        end
      end
      HIT, WIN: begin
        if (cnt_q <= 8'd1) begin
          state_d = (lives_q == 2'd0) ? OVER : PLAY;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OVER: ;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hardReset) begin
      state_q <= PLAY;
      x_q     <= START_X;
      y_q     <= START_Y;
      lives_q <= LIVES_INIT;
      score_q <= 4'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frog_x    = x_q;
  assign frog_y    = y_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign hit       = (state_q == HIT);
  assign win       = (state_q == WIN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_frog_tracker.sv
// Directed self-checking bench for frog_tracker (default parameters).
module tb_frog_tracker;

  logic              clk;
  logic              hardReset;
  logic              up, down, left, right;
  logic [15:0][15:0] lanes;
  logic [3:0]        frog_x, frog_y;
  logic              hit, win, game_over;
  logic [1:0]        lives;
  logic [3:0]        score;

  int n_checks = 0;
  int n_fail   = 0;

  frog_tracker dut (
    .clk       (clk),
    .hardReset (hardReset),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .lanes     (lanes),
    .frog_x    (frog_x),
    .frog_y    (frog_y),
    .hit       (hit),
    .win       (win),
    .lives     (lives),
    .score     (score),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
    step();
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic do_reset();
    hardReset = 1'b1;
    step();
    hardReset = 1'b0;
  endtask

  task automatic test_reset();
    lanes = '0;
    do_reset();
    n_checks++; if (frog_x !== 4'd7) begin n_fail++; $display("FAIL reset_x: got %0d want 7", frog_x); end
    n_checks++; if (frog_y !== 4'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", frog_y); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_checks++; if (score !== 4'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    n_checks++; if ({hit, win, game_over} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {hit, win, game_over}); end
  endtask

  task automatic test_move_right();
    lanes = '0;
    do_reset();
    pulse(0, 0, 0, 1);
    n_checks++; if (frog_x !== 4'd8) begin n_fail++; $display("FAIL right_x: got %0d want 8", frog_x); end
    n_checks++; if (frog_y !== 4'd0) begin n_fail++; $display("FAIL right_y: got %0d want 0", frog_y); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL right_hit: got %b want 0", hit); end
    for (int i = 0; i < 8; i++) pulse(0, 0, 0, 1);
`ifdef FROG_WRAP_EN
    n_checks++; if (frog_x !== 4'd0) begin n_fail++; $display("FAIL right_edge: got %0d want 0", frog_x); end
`else
    n_checks++; if (frog_x !== 4'd15) begin n_fail++; $display("FAIL right_edge: got %0d want 15", frog_x); end
`endif
    pulse(0, 1, 0, 0);
    n_checks++; if (frog_y !== 4'd0) begin n_fail++; $display("FAIL down_sat: got %0d want 0", frog_y); end
  endtask

  task automatic test_hit();
    lanes = '0;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
    n_checks++; if (frog_y !== 4'd3) begin n_fail++; $display("FAIL hit_setup_y: got %0d want 3", frog_y); end
    lanes[4] = 16'h0080;
    pulse(1, 0, 0, 0);
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_rise: got %b want 1", hit); end
    n_checks++; if (lives !== 2'd2) begin n_fail++; $display("FAIL hit_lives: got %0d want 2", lives); end
    n_checks++; if ({frog_x, frog_y} !== {4'd7, 4'd0}) begin n_fail++; $display("FAIL hit_pos: got (%0d,%0d) want (7,0)", frog_x, frog_y); end
    for (int i = 1; i < 8; i++) begin
      if (i == 3) pulse(0, 0, 1, 0);
      else step();
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_hold%0d: got %b want 1", i, hit); end
    end
    n_checks++; if (frog_x !== 4'd7) begin n_fail++; $display("FAIL hit_frozen_x: got %0d want 7", frog_x); end
    step();
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_fall: got %b want 0", hit); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL hit_to_play: got %b want 0", game_over); end
    pulse(0, 0, 0, 1);
    n_checks++; if (frog_x !== 4'd8) begin n_fail++; $display("FAIL hit_play_move: got %0d want 8", frog_x); end
  endtask

  task automatic test_win();
    lanes = '0;
    do_reset();
    for (int i = 0; i < 14; i++) pulse(1, 0, 0, 0);
    n_checks++; if (frog_y !== 4'd14) begin n_fail++; $display("FAIL win_setup_y: got %0d want 14", frog_y); end
    pulse(1, 0, 0, 0);
    n_checks++; if (win !== 1'b1) begin n_fail++; $display("FAIL win_rise: got %b want 1", win); end
    n_checks++; if (score !== 4'd1) begin n_fail++; $display("FAIL win_score: got %0d want 1", score); end
    n_checks++; if ({frog_x, frog_y} !== {4'd7, 4'd0}) begin n_fail++; $display("FAIL win_pos: got (%0d,%0d) want (7,0)", frog_x, frog_y); end
    for (int i = 1; i < 8; i++) begin
      step();
      n_checks++; if (win !== 1'b1) begin n_fail++; $display("FAIL win_hold%0d: got %b want 1", i, win); end
    end
    step();
    n_checks++; if (win !== 1'b0) begin n_fail++; $display("FAIL win_fall: got %b want 0", win); end
    // Collision at the goal row beats the win.
    for (int i = 0; i < 14; i++) pulse(1, 0, 0, 0);
    lanes[15] = 16'h0080;
    pulse(1, 0, 0, 0);
    n_checks++; if ({hit, win} !== 2'b10) begin n_fail++; $display("FAIL goal_collide: got hit/win %b want 10", {hit, win}); end
    n_checks++; if (score !== 4'd1) begin n_fail++; $display("FAIL goal_collide_score: got %0d want 1", score); end
    lanes = '0;
  endtask

  task automatic test_game_over();
    int hits_seen;
    lanes = '0;
    do_reset();
    lanes[0] = 16'h0080;
    step();
    n_checks++; if ({hit, lives} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL over_first_hit: got hit=%b lives=%0d want 1,2", hit, lives); end
    hits_seen = 1;
    for (int i = 0; i < 200 && !game_over; i++) begin
      step();
      if (hit && lives == 2'd0) hits_seen = 3;
    end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_reached: got %b want 1", game_over); end
    n_checks++; if (hits_seen !== 3) begin n_fail++; $display("FAIL over_third_hit: got %0d want 3", hits_seen); end
    n_checks++; if (lives !== 2'd0) begin n_fail++; $display("FAIL over_lives: got %0d want 0", lives); end
    lanes = '0;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_checks++; if ({frog_x, frog_y} !== {4'd7, 4'd0}) begin n_fail++; $display("FAIL over_frozen: got (%0d,%0d) want (7,0)", frog_x, frog_y); end
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_sticky: got %b want 1", game_over); end
    do_reset();
    n_checks++; if ({game_over, lives} !== {1'b0, 2'd3}) begin n_fail++; $display("FAIL over_reset: got go=%b lives=%0d want 0,3", game_over, lives); end
  endtask

  task automatic test_left_edge();
    lanes = '0;
    do_reset();
    for (int i = 0; i < 7; i++) pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    n_checks++; if ({frog_x, frog_y} !== {4'd0, 4'd2}) begin n_fail++; $display("FAIL edge_setup: got (%0d,%0d) want (0,2)", frog_x, frog_y); end
    lanes[2] = 16'h8000;
    pulse(0, 0, 1, 0);
`ifdef FROG_WRAP_EN
    n_checks++; if ({hit, lives} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL edge_wrap_hit: got hit=%b lives=%0d want 1,2", hit, lives); end
`else
    n_checks++; if (frog_x !== 4'd0) begin n_fail++; $display("FAIL edge_sat_x: got %0d want 0", frog_x); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL edge_sat_hit: got %b want 0", hit); end
`endif
    lanes = '0;
  endtask

  task automatic test_priority_and_reset();
    lanes = '0;
    do_reset();
    pulse(1, 0, 0, 1);
    n_checks++; if ({frog_x, frog_y} !== {4'd7, 4'd1}) begin n_fail++; $display("FAIL prio_up_right: got (%0d,%0d) want (7,1)", frog_x, frog_y); end
    pulse(0, 0, 1, 1);
    n_checks++; if (frog_x !== 4'd6) begin n_fail++; $display("FAIL prio_left_right: got %0d want 6", frog_x); end
    pulse(0, 1, 0, 1);
    n_checks++; if ({frog_x, frog_y} !== {4'd6, 4'd0}) begin n_fail++; $display("FAIL prio_down_right: got (%0d,%0d) want (6,0)", frog_x, frog_y); end
    // Car driving onto a stationary frog.
    lanes[0] = 16'h0040;
    step();
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL still_collide: got %b want 1", hit); end
    lanes = '0;
    step();
    step();
    hardReset = 1'b1;
    up = 1'b1; right = 1'b1;
    step();
    hardReset = 1'b0;
    up = 1'b0; right = 1'b0;
    n_checks++; if ({hit, win, game_over} !== 3'b000) begin n_fail++; $display("FAIL midhit_reset_flags: got %b want 000", {hit, win, game_over}); end
    n_checks++; if ({frog_x, frog_y, lives, score} !== {4'd7, 4'd0, 2'd3, 4'd0}) begin n_fail++; $display("FAIL midhit_reset_vals: got x=%0d y=%0d l=%0d s=%0d want 7,0,3,0", frog_x, frog_y, lives, score); end
  endtask

  initial begin
    hardReset = 1'b1;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    lanes = '0;
    test_reset();
    test_move_right();
    test_hit();
    test_win();
    test_game_over();
    test_left_edge();
    test_priority_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frog_tracker.md
FROG_TRACKER -- requirements
Module: frog_tracker

Interface
REQ-001 Parameter START_LIVES, default 3: lives loaded at reset, range 1..3.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles spent in HIT or WIN before returning to play, range 1..255.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 hardReset  input  1  synchronous, active-high reset.
REQ-005 up, down, left, right  input  1 each  single-cycle move pulses.
REQ-006 lanes  input  [15:0][15:0]  lane occupancy; lanes[y] = car column word of row y, bit 15 = rightmost column, bit 0 = leftmost.
REQ-007 frog_x  output  4  frog column, 0 = leftmost.
REQ-008 frog_y  output  4  frog row, 0 = start row, 15 = goal row.
REQ-009 hit  output  1  high while in HIT.
REQ-010 win  output  1  high while in WIN.
REQ-011 lives  output  2  remaining lives.
REQ-012 score  output  4  completed crossings.
REQ-013 game_over  output  1  high while in OVER.

Function
REQ-014 FSM states: PLAY, HIT, WIN, OVER; all outputs registered.
REQ-015 PLAY: at most one move per cycle; priority up > down > left > right; other pulses that cycle are dropped.
REQ-016 up: y+1; down: y-1; right: x+1; left: x-1; y saturates at 0 and 15.
REQ-017 x saturates at 0 and 15 unless FROG_WRAP_EN is defined (REQ-030).
REQ-018 Candidate position (nx, ny) = position after the move, or current position if no move.
REQ-019 Collision when lanes[ny][nx] = 1, sampled the same cycle; a car moving onto a stationary frog is also a collision.
REQ-020 Collision in PLAY: next cycle state HIT, lives-1, position (7,0), hold counter loaded with HOLD_CYCLES.
REQ-021 No collision and ny = 15: next cycle state WIN, score+1 (saturates at 15), position (7,0), hold counter loaded.
REQ-022 Collision takes priority over win in the same cycle.
REQ-023 HIT/WIN: moves and lanes ignored; position frozen; counter decrements each cycle; at count 1, next state is OVER if lives = 0, else PLAY.
REQ-024 hit/win are high for exactly HOLD_CYCLES cycles.
REQ-025 OVER: sticky until hardReset; game_over = 1; position frozen; moves ignored.
REQ-026 No other path leaves OVER.

Reset
REQ-027 hardReset on a clock edge sets state PLAY, frog_x = 7, frog_y = 0, lives = START_LIVES, score = 0, hit = win = game_over = 0, hold counter = 0.
REQ-028 hardReset overrides every state, including mid-HIT, mid-WIN and OVER, and all move inputs in the same cycle.
REQ-029 No collision is evaluated in the reset cycle.

Configuration
REQ-030 Macro FROG_WRAP_EN.
- Defined: left at x = 0 gives x = 15; right at x = 15 gives x = 0; the collision check uses the wrapped column.
- Undefined: x saturates at 0 and 15.
- y behaviour is identical in both builds.

Structure
REQ-031 Package frog_pkg holds:
- the state enum (PLAY, HIT, WIN, OVER);
- GRID_W = 16, GRID_H = 16;
- START_X = 7, START_Y = 0, GOAL_Y = 15.
REQ-032 One sub-module, frog_step:
- combinational;
- inputs: position and move pulses;
- output: candidate position, with priority, saturation and wrap applied.
REQ-033 Collision lookup and the FSM live in frog_tracker.

Verification
REQ-034 Reset, then right pulse with lanes all 0 -> next cycle frog_x = 8, frog_y = 0, hit = 0.
REQ-035 Frog at (7,3); lanes[4] = 16'h0080; up pulse -> next cycle hit = 1, lives 3 -> 2, position (7,0); hit stays high 8 cycles, then PLAY.
REQ-036 Frog at (7,14); lanes[15] = 0; up pulse -> win = 1 for 8 cycles, score 0 -> 1, position (7,0).
REQ-037 Three successive collisions from reset -> after the third hold expires, game_over = 1 and lives = 0; further moves do not change the position; hardReset -> lives = 3, game_over = 0.
REQ-038 Frog at (0,2); left pulse -> without FROG_WRAP_EN frog_x stays 0; with FROG_WRAP_EN frog_x = 15 and lanes[2] bit 15 is checked.
REQ-039 Up and right pulsed together at (7,0) -> frog_y = 1, frog_x = 7; hardReset asserted mid-HIT -> all outputs at reset values next cycle.
